// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared types and constants for the parallel-in / serial-out shift register.
//   state_t            : controller state (IDLE, SHIFT)
//   PISO_WIDTH_DEFAULT : default parallel word width
// ---------------------------------------------------------------------------
package piso_pkg;

   localparam int unsigned PISO_WIDTH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage : piso_pkg

// File: rtl/piso_shift_reg.sv
// ---------------------------------------------------------------------------
// piso_shift_reg
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per clock, with a per-bit valid and a final-bit marker. A new word may be
// accepted on the final bit of the current one, so words stream with no gap.
//
// Build option:
//   PISO_MSB_FIRST_EN defined   : d_i[WIDTH-1] goes out first (left shift)
//   PISO_MSB_FIRST_EN undefined : d_i[0] goes out first (right shift)
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   load_valid_i  in   word on d_i is offered
//   load_ready_o  out  a word can be accepted this cycle
//   d_i           in   parallel word, WIDTH bits
//   sout_o        out  current serial bit (0 when not valid)
//   sout_valid_o  out  sout_o carries a valid bit
//   last_o        out  sout_o is the final bit of the current word
//
// All outputs come straight from flops; their next values are derived from
// the next-state values so they line up with the state they describe.
// ---------------------------------------------------------------------------
module piso_shift_reg
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] d_i,
   output logic             sout_o,
   output logic             sout_valid_o,
   output logic             last_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic               load_ready_q, load_ready_d;
   logic               sout_q,       sout_d;
   logic               sout_valid_q, sout_valid_d;
   logic               last_q,       last_d;

   logic               accept_c;
   logic [WIDTH-1:0]   shreg_shifted_c;
   logic               out_bit_c;

   // Handshake completes against the registered ready only.
   assign accept_c = load_valid_i & load_ready_q;

   // Shift direction and output tap follow the build option.
`ifdef PISO_MSB_FIRST_EN
   assign shreg_shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
   assign out_bit_c       = shreg_d[WIDTH-1];
`else
   assign shreg_shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
   assign out_bit_c       = shreg_d[0];
`endif

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: load on accept, otherwise shift and count down to zero.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = SHIFT;
               shreg_d = d_i;
               cnt_d   = CNT_LOAD;
            end
         end
         SHIFT: begin
            if (accept_c) begin
               // Only reachable on the final bit: chain straight into the next word.
               state_d = SHIFT;
               shreg_d = d_i;
               cnt_d   = CNT_LOAD;
            end else begin
               shreg_d = shreg_shifted_c;
               if (cnt_q == CNT_ZERO) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output next values, decoded from next state so the flops match it.
   always_comb begin
      sout_valid_d = 1'b0;
      last_d       = 1'b0;
      load_ready_d = 1'b1;
      sout_d       = 1'b0;
      if (state_d == SHIFT) begin
         sout_valid_d = 1'b1;
         last_d       = (cnt_d == CNT_ZERO);
         load_ready_d = last_d;
         sout_d       = out_bit_c;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_ready_q <= 1'b1;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         load_ready_q <= load_ready_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         last_q       <= last_d;
      end
   end

   assign load_ready_o = load_ready_q;
   assign sout_o       = sout_q;
   assign sout_valid_o = sout_valid_q;
   assign last_o       = last_q;

endmodule : piso_shift_reg
